// File: rtl/network_tx_arbiter_pkg.sv
// Shared types and defaults for the serial-link transmit arbiter.
package network_tx_arbiter_pkg;

  // Payload mux select presented to the serial sender.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ACK  = 2'd1,
    SEL_DATA = 2'd2
  } tx_sel_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_ACK  = 2'd1,
    ST_SEND_DATA = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_t;

  localparam int DEFAULT_GAP_CYCLES     = 4;
  localparam int DEFAULT_ACK_STREAK_MAX = 2;

  // Width of the gap counter and ACK streak counter (GAP_CYCLES <= 255).
  localparam int GAP_CNT_W = 8;
  localparam int STREAK_W  = 8;

endpackage

// File: rtl/tx_gap_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
module tx_gap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load takes precedence over decrement; decrement never wraps below zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/network_tx_arbiter.sv
// Shares the serial transmitter between the ACK and data paths.
// ACK wins arbitration unless it has already taken ACK_STREAK_MAX grants
// while data was waiting; a fixed idle gap follows every packet.
module network_tx_arbiter
  import network_tx_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int ACK_STREAK_MAX = DEFAULT_ACK_STREAK_MAX
) (
  input  logic    clk,
  input  logic    rst_l,
  input  logic    game_active,
  input  logic    ack_req,
  input  logic    data_req,
  input  logic    tx_done,
  output logic    tx_start,
  output tx_sel_t tx_sel,
  output logic    tx_abort,
  output logic    ack_sent,
  output logic    data_sent,
  output logic    busy
);

  // Gap counter starts at GAP_CYCLES-1 so the GAP state lasts GAP_CYCLES cycles.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(ACK_STREAK_MAX);
  // With no gap configured a finished packet returns straight to IDLE.
  localparam arb_state_t POST_SEND = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t            r_state;
  logic                  r_ack_pend;
  logic                  r_data_pend;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_tx_start;
  tx_sel_t               r_tx_sel;
  logic                  r_tx_abort;
  logic                  r_ack_sent;
  logic                  r_data_sent;
  logic                  r_busy;

  arb_state_t            w_state_nxt;
  tx_sel_t               w_sel_nxt;
  logic                  w_ack_grant;
  logic                  w_data_grant;
  logic                  w_ack_fin;
  logic                  w_data_fin;
  logic                  w_abort;
  logic                  w_gap_load;
  logic                  w_gap_dec;
  logic                  w_gap_zero;

  tx_gap_counter #(
    .W (GAP_CNT_W)
  ) u_gap_counter (
    .clk        (clk),
    .rst_l      (rst_l),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

  // Next-state, grant and completion decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_ack_grant  = 1'b0;
    w_data_grant = 1'b0;
    w_ack_fin    = 1'b0;
    w_data_fin   = 1'b0;
    w_abort      = 1'b0;
    w_gap_load   = 1'b0;
    w_gap_dec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ack_pend && (!r_data_pend || (r_streak < STREAK_MAX))) begin
          w_ack_grant = 1'b1;
          w_state_nxt = ST_SEND_ACK;
        end else if (r_data_pend && game_active) begin
          w_data_grant = 1'b1;
          w_state_nxt  = ST_SEND_DATA;
        end
      end
      ST_SEND_ACK: begin
        if (tx_done) begin
          w_ack_fin   = 1'b1;
          w_gap_load  = 1'b1;
          w_state_nxt = POST_SEND;
        end
      end
      ST_SEND_DATA: begin
        // A completion in the same cycle as game_active falling still counts.
        if (tx_done) begin
          w_data_fin  = 1'b1;
          w_gap_load  = 1'b1;
          w_state_nxt = POST_SEND;
        end else if (!game_active) begin
          w_abort     = 1'b1;
          w_gap_load  = 1'b1;
          w_state_nxt = POST_SEND;
        end
      end
      ST_GAP: begin
        if (w_gap_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Payload select follows the state being entered.
  always_comb begin
    w_sel_nxt = SEL_NONE;
    if (w_state_nxt == ST_SEND_ACK) begin
      w_sel_nxt = SEL_ACK;
    end else if (w_state_nxt == ST_SEND_DATA) begin
      w_sel_nxt = SEL_DATA;
    end
  end

  // State register and request latches; a pulse on the grant cycle re-arms pend.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= ST_IDLE;
      r_ack_pend  <= 1'b0;
      r_data_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack_pend  <= (r_ack_pend & ~w_ack_grant) | ack_req;
      r_data_pend <= ((r_data_pend & ~w_data_grant) | data_req) & game_active;
    end
  end

  // Counts ACK grants taken while data waits; cleared once data is served or gone.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_streak <= '0;
    end else if (!r_data_pend || w_data_grant) begin
      r_streak <= '0;
    end else if (w_ack_grant && (r_streak < STREAK_MAX)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // Registered outputs toward the sender and the requesting FSMs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_tx_start  <= 1'b0;
      r_tx_sel    <= SEL_NONE;
      r_tx_abort  <= 1'b0;
      r_ack_sent  <= 1'b0;
      r_data_sent <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tx_start  <= w_ack_grant | w_data_grant;
      r_tx_sel    <= w_sel_nxt;
      r_tx_abort  <= w_abort;
      r_ack_sent  <= w_ack_fin;
      r_data_sent <= w_data_fin;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign tx_start  = r_tx_start;
  assign tx_sel    = r_tx_sel;
  assign tx_abort  = r_tx_abort;
  assign ack_sent  = r_ack_sent;
  assign data_sent = r_data_sent;
  assign busy      = r_busy;

endmodule

// File: doc/network_tx_arbiter.md
Name: network_tx_arbiter

Overview:
- Shares the single serial link transmitter between the data sender path and the ACK path.
- Latches one-cycle request pulses from each requester, grants the transmitter to one at a time, and enforces an inter-packet gap.
- Returns a completion pulse to the requester that was served. The data-side completion is the data sender control FSM's send_done.
- ACK has priority, with a bounded streak so data cannot starve. Sits between the data/ACK control FSMs and the serial sender.

Parameters:
- GAP_CYCLES, 4, idle clk cycles forced between end of one packet and next tx_start (0..255; 0 = no gap state).
- ACK_STREAK_MAX, 2, max consecutive ACK grants while data is pending before data is granted (>=1).

Ports:
- clk  input  1  GPIO clock; one clock domain.
- rst_l  input  1  asynchronous active-low reset.
- game_active  input  1  game in progress; data traffic allowed only when high.
- ack_req  input  1  1-cycle pulse: an ACK must be sent.
- data_req  input  1  1-cycle pulse: data packet ready (driven by data FSM send_start).
- tx_done  input  1  serial sender finished current packet (1-cycle pulse).
- tx_start  output  1  1-cycle pulse: serial sender loads payload selected by tx_sel and begins.
- tx_sel  output  2  tx_sel_t: SEL_NONE / SEL_ACK / SEL_DATA; payload mux select.
- tx_abort  output  1  1-cycle pulse: sender must drop current packet.
- ack_sent  output  1  1-cycle pulse: ACK transmission complete.
- data_sent  output  1  1-cycle pulse: data transmission complete (data FSM send_done).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0; tx_sel = SEL_NONE; state IDLE.
  - ack_pend = 0, data_pend = 0, streak = 0, gap_cnt = 0.
- Pending latches:
  - ack_pend_next = (ack_pend & ~ack_grant) | ack_req.
  - data_pend_next = ((data_pend & ~data_grant) | data_req) & game_active.
  - A request pulse arriving on the grant cycle of the same type re-sets pend, so a second packet follows.
  - Repeated pulses while already pending coalesce to one.
- States: IDLE, SEND_ACK, SEND_DATA, GAP. All outputs are registered.
- IDLE:
  - ack_grant if ack_pend & (~data_pend | streak < ACK_STREAK_MAX) -> SEND_ACK.
  - Else data_grant if data_pend & game_active -> SEND_DATA.
  - Else stay in IDLE.
- Grant behaviour:
  - On grant, tx_start = 1 for exactly the first cycle of the SEND state.
  - tx_sel is set to the granted type and held for the entire SEND state.
- Latency: request pulse in cycle N with arbiter idle -> tx_start in cycle N+2.
- Streak counter:
  - Increments on an ACK grant while data_pend = 1, saturating at ACK_STREAK_MAX.
  - Clears on data grant, or whenever data_pend = 0.
- SEND_ACK:
  - On tx_done: ack_sent = 1 next cycle; go to GAP (or IDLE if GAP_CYCLES = 0).
  - Ignores game_active.
- SEND_DATA:
  - On tx_done: data_sent = 1 next cycle; go to GAP or IDLE.
  - If game_active falls before tx_done: tx_abort = 1 next cycle, no data_sent, go to GAP.
  - If tx_done and game_active fall in the same cycle, tx_done wins and data_sent is issued.
- GAP:
  - gap_cnt loads GAP_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to IDLE. The earliest next tx_start is GAP_CYCLES+2 cycles after tx_done.
  - Requests are still latched during GAP.
- On leaving a SEND state, tx_sel returns to SEL_NONE.
- tx_done in IDLE or GAP is ignored.
- Asynchronous reset mid-packet returns to IDLE with all pending requests lost. No abort pulse is generated.

Decomposition:
- NetworkPkg: tx_sel_t enum (SEL_NONE = 2'd0, SEL_ACK = 2'd1, SEL_DATA = 2'd2), arbiter state enum, default GAP_CYCLES / ACK_STREAK_MAX constants.
- One sub-module: tx_gap_counter (loadable down-counter with a zero flag), reusable by the timeout logic.

Test Plan:
- Single data_req at cycle 10, game_active = 1 -> tx_start and tx_sel = SEL_DATA at cycle 12; tx_done at 20 -> data_sent at 21; busy low at 21+GAP_CYCLES=25.
- ack_req and data_req in the same cycle -> ACK served first; after its ack_sent and a 4-cycle gap, data tx_start occurs; streak = 1 then clears on the data grant.
- ACK flood with ACK_STREAK_MAX = 2, data pending -> grant order ACK, ACK, DATA, ACK…; data is never delayed by more than 2 ACK packets.
- game_active drops mid SEND_DATA -> tx_abort pulse one cycle later, no data_sent, data_pend = 0; a pending ACK is still sent after the gap.
- data_req pulsed 3 times during SEND_DATA -> exactly one extra data packet follows; ack_req arriving during GAP -> tx_start two cycles after GAP ends.
- rst_l asserted during SEND_ACK -> all outputs 0 and tx_sel = SEL_NONE immediately; tx_done after release is ignored.
